frame_window_trigger: RTL



---
 rtl/frame_trig_pkg.sv | 14 +
 rtl/frame_trig_edge.sv | 19 +
 rtl/frame_window_trigger.sv | 132 +++++++++++++
 3 files changed

// File: rtl/frame_trig_pkg.sv
// Shared state encoding for the frame-window trigger.
package frame_trig_pkg;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ACTIVE = 2'd2,
    S_DONE   = 2'd3
  } trig_st_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
endpackage

// File: rtl/frame_trig_edge.sv
// Registered previous value and a single-cycle edge pulse.
// POL=1 selects the rising edge, POL=0 the falling edge.
module frame_trig_edge #(
  parameter bit POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic d_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_l <= 1'b0;
    else     d_l <= d;
  end

  assign pulse = POL ? (~d_l & d) : (d_l & ~d);
endmodule

// File: rtl/frame_window_trigger.sv
// Frame-window capture trigger: counts vsync frames after ROM download and
// opens a per-channel capture enable for a configured window of frames.
//   state  | meaning
//   IDLE   | waiting for arm or end of download
//   ARMED  | waiting for the start frame
//   ACTIVE | window open, dump_en = mask
//   DONE   | window closed, waiting for re-arm
module frame_window_trigger
  import frame_trig_pkg::*;
#(
  parameter int             FW         = 32,
  parameter int             NCH        = 4,
  parameter logic [FW-1:0]  DEF_START  = '0,
  parameter logic [FW-1:0]  DEF_LEN    = '0,
  parameter logic [NCH-1:0] DEF_MASK   = '1,
  parameter bit             VS_POL     = 1'b0,
  parameter bit             WAIT_DWNLD = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vs,
  input  logic           dwnld,
  input  logic           cfg_we,
  input  logic [FW-1:0]  cfg_start,
  input  logic [FW-1:0]  cfg_len,
  input  logic [NCH-1:0] cfg_mask,
  input  logic           arm,
  input  logic           abort,
  output logic [FW-1:0]  frame_cnt,
  output logic [NCH-1:0] dump_en,
  output logic           active,
  output logic           done,
  output logic [1:0]     st
);
  localparam logic [FW-1:0] ONE = FW'(1);
  localparam trig_st_t RST_ST = WAIT_DWNLD ? S_IDLE : S_ARMED;

  logic           fedge, dfall;
  logic [FW-1:0]  cnt_nxt, wcnt, wcnt_nxt;
  logic [FW-1:0]  start, len;
  logic [NCH-1:0] mask;
  trig_st_t       state, st_nxt;

  frame_trig_edge #(.POL(VS_POL)) u_vs_edge (
    .clk(clk), .rst(rst), .d(vs), .pulse(fedge)
  );

  frame_trig_edge #(.POL(1'b0)) u_dw_edge (
    .clk(clk), .rst(rst), .d(dwnld), .pulse(dfall)
  );

  // end of download restarts the frame count even if a frame edge coincides
  always_comb begin
    cnt_nxt = frame_cnt;
    if (dfall)                     cnt_nxt = '0;
    else if (fedge && ~&frame_cnt) cnt_nxt = frame_cnt + ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt <= '0;
    else     frame_cnt <= cnt_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start <= DEF_START;
      len   <= DEF_LEN;
      mask  <= DEF_MASK;
    end else if (cfg_we && (state == S_IDLE || state == S_DONE)) begin
      start <= cfg_start;
      len   <= cfg_len;
      mask  <= cfg_mask;
    end
  end

  always_comb begin
    st_nxt   = state;
    wcnt_nxt = wcnt;
    if (abort) begin
      st_nxt = S_IDLE;
    end else if (WAIT_DWNLD && dwnld) begin
      st_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (arm || (WAIT_DWNLD && dfall)) begin
            st_nxt   = S_ARMED;
            wcnt_nxt = '0;
          end
        end
        S_ARMED: begin
          // compare against the count as it will be after this edge
          if (fedge && cnt_nxt >= start) begin
            st_nxt   = S_ACTIVE;
            wcnt_nxt = ONE;
          end
        end
        S_ACTIVE: begin
          if (fedge) begin
            if (len != '0 && wcnt == len) st_nxt = S_DONE;
            else if (~&wcnt)              wcnt_nxt = wcnt + ONE;
          end
        end
        S_DONE: begin
          if (arm) begin
            st_nxt   = S_ARMED;
            wcnt_nxt = '0;
          end
        end
        default: st_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RST_ST;
      wcnt    <= '0;
      dump_en <= '0;
      active  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= st_nxt;
      wcnt    <= wcnt_nxt;
      dump_en <= (st_nxt == S_ACTIVE) ? mask : '0;
      active  <= (st_nxt == S_ACTIVE);
      done    <= (st_nxt == S_DONE);
    end
  end

  assign st = state;
endmodule
